// File: rtl/dp_group_sched.sv
// Tile sequencer for one dp_group: streams K operand beats, drains the pipeline, hands off result.
// Optional DP_SCHED_PERF_EN adds a saturating stall_cnt output.
module dp_group_sched #(
  parameter int unsigned DW_CNT   = 16,
  parameter int unsigned PIPE_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DW_CNT-1:0] cmd_len,
  input  logic              op_valid,
  output logic              op_ready,
  output logic              dp_enable,
  output logic [1:0]        dp_valid,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              busy,
  output logic [DW_CNT-1:0] step_cnt
`ifdef DP_SCHED_PERF_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  localparam logic [3:0] DrainInit = 4'(PIPE_LAT - 1);

  state_e            state_q;
  logic [DW_CNT-1:0] len_q;
  logic [DW_CNT-1:0] step_q;
  logic [3:0]        drain_q;
  logic              beat;

  always_comb begin
    // cmd_ready is masked by reset so nothing is offered while reset is held
    cmd_ready = (state_q == StIdle) & reset;
    op_ready  = (state_q == StRun);
    beat      = op_ready & op_valid;
    dp_enable = beat | (state_q == StDrain);
    dp_valid  = {beat & (step_q == '0), beat};
    res_valid = (state_q == StDone);
    busy      = (state_q != StIdle);
    step_cnt  = step_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      len_q   <= '0;
      step_q  <= '0;
      drain_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            len_q   <= cmd_len;
            step_q  <= '0;
            state_q <= (cmd_len != '0) ? StRun : StDone;
          end
        end
        StRun: begin
          if (op_valid) begin
            step_q <= step_q + DW_CNT'(1);
            if (step_q == len_q - DW_CNT'(1)) begin
              state_q <= StDrain;
              drain_q <= DrainInit;
            end
          end
        end
        StDrain: begin
          if (drain_q == '0) begin
            state_q <= StDone;
          end else begin
            drain_q <= drain_q - 4'd1;
          end
        end
        StDone: begin
          if (res_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef DP_SCHED_PERF_EN
  logic [31:0] stall_q;
  logic        stall_evt;

  assign stall_evt = ((state_q == StRun) & ~op_valid) | ((state_q == StDone) & ~res_ready);
  assign stall_cnt = stall_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
    end else if (stall_evt && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dp_group_sched.sv
// Directed self-checking bench for dp_group_sched (PIPE_LAT=2, DW_CNT=16).
module tb_dp_group_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_len;
  logic        op_valid;
  logic        op_ready;
  logic        dp_enable;
  logic [1:0]  dp_valid;
  logic        res_valid;
  logic        res_ready;
  logic        busy;
  logic [15:0] step_cnt;
`ifdef DP_SCHED_PERF_EN
  logic [31:0] stall_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dp_group_sched #(
    .DW_CNT  (16),
    .PIPE_LAT(2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_len  (cmd_len),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .dp_enable(dp_enable),
    .dp_valid (dp_valid),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .busy     (busy),
    .step_cnt (step_cnt)
`ifdef DP_SCHED_PERF_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [4:0] pat;
    logic       first;

    reset     = 1'b0;
    cmd_valid = 1'b0;
    cmd_len   = '0;
    op_valid  = 1'b0;
    res_ready = 1'b0;

    // Reset values
    #3;
    check("rst_cmd_ready", 32'(cmd_ready), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_dp_enable", 32'(dp_enable), 0);
    check("rst_dp_valid", 32'(dp_valid), 0);
    check("rst_op_ready", 32'(op_ready), 0);
    check("rst_res_valid", 32'(res_valid), 0);
    check("rst_step_cnt", 32'(step_cnt), 0);
    #9 reset = 1'b1;
    cyc();
    check("idle_cmd_ready", 32'(cmd_ready), 1);

    // Basic tile: len=4, continuous operands
    cmd_valid = 1'b1; cmd_len = 16'd4; op_valid = 1'b1; res_ready = 1'b1;
    cyc();
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("basic_run_en", 32'(dp_enable), 1);
      check("basic_run_valid", 32'(dp_valid), (i == 0) ? 3 : 1);
      check("basic_cmd_ready", 32'(cmd_ready), 0);
      cyc();
    end
    for (int i = 0; i < 2; i++) begin
      #1;
      check("basic_drain_en", 32'(dp_enable), 1);
      check("basic_drain_valid", 32'(dp_valid), 0);
      check("basic_drain_op_ready", 32'(op_ready), 0);
      check("basic_drain_res", 32'(res_valid), 0);
      cyc();
    end
    check("basic_res_valid", 32'(res_valid), 1);
    check("basic_step_cnt", 32'(step_cnt), 4);
    check("basic_done_en", 32'(dp_enable), 0);
    cyc();
    check("basic_res_drop", 32'(res_valid), 0);
    check("basic_idle", 32'(cmd_ready), 1);

    // Bubbles: len=3, op_valid 1,0,0,1,1, then 3-cycle res_ready stall
    op_valid = 1'b0; res_ready = 1'b0;
    cmd_valid = 1'b1; cmd_len = 16'd3;
    cyc();
    cmd_valid = 1'b0;
    pat = 5'b11001;
    first = 1'b1;
    for (int i = 0; i < 5; i++) begin
      op_valid = pat[i];
      #1;
      check("bub_en", 32'(dp_enable), 32'(pat[i]));
      check("bub_valid", 32'(dp_valid), pat[i] ? (first ? 3 : 1) : 0);
      check("bub_step", 32'(step_cnt), (i == 0) ? 0 : (i < 3) ? 1 : i - 2);
      if (pat[i]) first = 1'b0;
      cyc();
    end
    op_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("bub_drain_en", 32'(dp_enable), 1);
      check("bub_drain_res", 32'(res_valid), 0);
      cyc();
    end
    for (int i = 0; i < 3; i++) begin
      check("bub_hold_res", 32'(res_valid), 1);
      check("bub_hold_en", 32'(dp_enable), 0);
      check("bub_hold_cmd_ready", 32'(cmd_ready), 0);
      cyc();
    end
    res_ready = 1'b1;
    #1;
    check("bub_res_valid", 32'(res_valid), 1);
    check("bub_step_cnt", 32'(step_cnt), 3);
    cyc();
    check("bub_idle", 32'(busy), 0);
`ifdef DP_SCHED_PERF_EN
    check("perf_stall_cnt", stall_cnt, 5);
`endif

    // Backpressure: len=2, res_ready low for 5 cycles
    res_ready = 1'b0; op_valid = 1'b1;
    cmd_valid = 1'b1; cmd_len = 16'd2;
    cyc();
    cmd_valid = 1'b1; // ignored outside IDLE
    repeat (4) cyc();
    for (int i = 0; i < 5; i++) begin
      check("bp_res_valid", 32'(res_valid), 1);
      check("bp_en", 32'(dp_enable), 0);
      check("bp_cmd_ready", 32'(cmd_ready), 0);
      cyc();
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    cyc();
    check("bp_back_idle", 32'(busy), 0);
    check("bp_cmd_ready_after", 32'(cmd_ready), 1);
    op_valid = 1'b0;

    // Zero-length tile
    cmd_valid = 1'b1; cmd_len = 16'd0;
    #1;
    check("zero_hs_en", 32'(dp_enable), 0);
    cyc();
    cmd_valid = 1'b0;
    #1;
    check("zero_res_valid", 32'(res_valid), 1);
    check("zero_en", 32'(dp_enable), 0);
    check("zero_step", 32'(step_cnt), 0);
    cyc();
    check("zero_idle", 32'(busy), 0);

    // Async reset in the middle of a len=5 tile
    op_valid = 1'b1; cmd_valid = 1'b1; cmd_len = 16'd5;
    cyc();
    cmd_valid = 1'b0;
    cyc();
    cyc();
    #1;
    check("ar_step_before", 32'(step_cnt), 2);
    check("ar_busy_before", 32'(busy), 1);
    #2 reset = 1'b0;
    #1;
    check("ar_en", 32'(dp_enable), 0);
    check("ar_valid", 32'(dp_valid), 0);
    check("ar_busy", 32'(busy), 0);
    check("ar_cmd_ready", 32'(cmd_ready), 0);
    check("ar_op_ready", 32'(op_ready), 0);
    check("ar_step", 32'(step_cnt), 0);
    #2 reset = 1'b1;
    cyc();
    cmd_valid = 1'b1; cmd_len = 16'd1;
    #1;
    check("ar_new_cmd_ready", 32'(cmd_ready), 1);
    cyc();
    cmd_valid = 1'b0;
    #1;
    check("ar_new_valid", 32'(dp_valid), 3);
    check("ar_new_en", 32'(dp_enable), 1);
    cyc();
    cyc();
    cyc();
    check("ar_new_res", 32'(res_valid), 1);
    check("ar_new_step", 32'(step_cnt), 1);
    cyc();
    check("ar_new_idle", 32'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
